la_delayctrl: RTL and testbench



---
 rtl/la_delayctrl.sv | 157 +++++++++++++++
 tb/tb_la_delayctrl.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/la_delayctrl.sv
// Lock controller for a tapped delay line: linear tap search on a voted phase-detector result.
// Optional LA_DELAYCTRL_TRACK_EN keeps adjusting the tap on unanimous windows after lock.
module la_delayctrl #(
    parameter int unsigned N       = 5,
    parameter int unsigned SETTLE  = 4,
    parameter int unsigned VOTES   = 8,
    parameter int unsigned TAPINIT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         phase_late,
    output logic [N-1:0] tap,
    output logic         busy,
    output logic         locked,
    output logic         error
);

    localparam int unsigned CntMax = (SETTLE > VOTES) ? SETTLE : VOTES;
    localparam int unsigned CW     = $clog2(CntMax + 1);
    localparam int unsigned LW     = $clog2(VOTES + 1);

    localparam logic [N-1:0]  TapMax    = {N{1'b1}};
    localparam logic [N-1:0]  TapInit   = N'(TAPINIT);
    localparam logic [CW-1:0] SettleCnt = CW'(SETTLE);
    localparam logic [CW-1:0] VoteCnt   = CW'(VOTES);
    localparam logic [CW-1:0] CntLast   = CW'(1);
    localparam logic [LW-1:0] HalfVotes = LW'(VOTES / 2);

    typedef enum logic [2:0] {StIdle, StSettle, StSample, StStep, StLocked} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  tap_q, tap_d;
    logic          busy_q, busy_d;
    logic          locked_q, locked_d;
    logic          error_q, error_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] late_cnt_q, late_cnt_d;
    logic          dir_valid_q, dir_valid_d;
    logic          dir_up_q, dir_up_d;
    logic          is_late, is_early;

    assign is_late  = late_cnt_q > HalfVotes;
    assign is_early = late_cnt_q < HalfVotes;

    always_comb begin
        state_d     = state_q;
        tap_d       = tap_q;
        busy_d      = busy_q;
        locked_d    = locked_q;
        error_d     = error_q;
        cnt_d       = cnt_q;
        late_cnt_d  = late_cnt_q;
        dir_valid_d = dir_valid_q;
        dir_up_d    = dir_up_q;

        if (start && !busy_q) begin
            state_d     = StSettle;
            tap_d       = TapInit;
            busy_d      = 1'b1;
            locked_d    = 1'b0;
            error_d     = 1'b0;
            cnt_d       = SettleCnt;
            late_cnt_d  = '0;
            dir_valid_d = 1'b0;
            dir_up_d    = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StSettle: begin
                    if (cnt_q == CntLast) begin
                        state_d    = StSample;
                        cnt_d      = VoteCnt;
                        late_cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q - CntLast;
                    end
                end
                StSample: begin
                    late_cnt_d = late_cnt_q + LW'(phase_late);
                    if (cnt_q == CntLast) begin
                        state_d = StStep;
                    end else begin
                        cnt_d = cnt_q - CntLast;
                    end
                end
                StStep: begin
`ifdef LA_DELAYCTRL_TRACK_EN
                    // Tracking after lock: move only on unanimous windows, saturate silently.
                    if (locked_q) begin
                        if (late_cnt_q == LW'(VOTES) && tap_q != '0) begin
                            tap_d = tap_q - 1'b1;
                        end else if (late_cnt_q == '0 && tap_q != TapMax) begin
                            tap_d = tap_q + 1'b1;
                        end
                        state_d = StSettle;
                        cnt_d   = SettleCnt;
                    end else
`endif
                    if ((!is_late && !is_early) || (dir_valid_q && (is_early != dir_up_q))) begin
                        // Tie, or the detector flipped relative to the last step.
                        state_d  = StLocked;
                        locked_d = 1'b1;
                        busy_d   = 1'b0;
                    end else if ((is_early && tap_q == TapMax) || (is_late && tap_q == '0)) begin
                        state_d = StIdle;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        tap_d       = is_early ? tap_q + 1'b1 : tap_q - 1'b1;
                        dir_valid_d = 1'b1;
                        dir_up_d    = is_early;
                        state_d     = StSettle;
                        cnt_d       = SettleCnt;
                    end
                end
                StLocked: begin
`ifdef LA_DELAYCTRL_TRACK_EN
                    state_d = StSettle;
                    cnt_d   = SettleCnt;
`endif
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            tap_q       <= TapInit;
            busy_q      <= 1'b0;
            locked_q    <= 1'b0;
            error_q     <= 1'b0;
            cnt_q       <= '0;
            late_cnt_q  <= '0;
            dir_valid_q <= 1'b0;
            dir_up_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            tap_q       <= tap_d;
            busy_q      <= busy_d;
            locked_q    <= locked_d;
            error_q     <= error_d;
            cnt_q       <= cnt_d;
            late_cnt_q  <= late_cnt_d;
            dir_valid_q <= dir_valid_d;
            dir_up_q    <= dir_up_d;
        end
    end

    assign tap    = tap_q;
    assign busy   = busy_q;
    assign locked = locked_q;
    assign error  = error_q;

endmodule

// File: tb/tb_la_delayctrl.sv
// Scoreboard bench for la_delayctrl: a search model predicts the final tap/flags/latency per start.
module tb_la_delayctrl;

    localparam int unsigned N       = 5;
    localparam int unsigned SETTLE  = 4;
    localparam int unsigned VOTES   = 8;
    localparam int unsigned TAPINIT = 0;
    localparam int Window = SETTLE + VOTES + 1;
    localparam int MaxTap = (1 << N) - 1;

    logic         clk = 1'b0;
    logic         clk_en = 1'b1;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic         phase_late;
    logic [N-1:0] tap;
    logic         busy, locked, error;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int mode = 1;   // 0: late when tap>=thr, 1: never late, 2: always late, 3: toggling
    int thr = 0;
    logic tog = 1'b0;

    typedef struct {
        int tap;
        int lock;
        int err;
        int lat;
        int start_cyc;
    } exp_t;

    exp_t exp_q[$];

    la_delayctrl #(.N(N), .SETTLE(SETTLE), .VOTES(VOTES), .TAPINIT(TAPINIT)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .phase_late (phase_late),
        .tap        (tap),
        .busy       (busy),
        .locked     (locked),
        .error      (error)
    );

    always #5 if (clk_en) clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        tog <= ~tog;
    end

    always_comb begin
        phase_late = 1'b0;
        case (mode)
            0: phase_late = (int'(tap) >= thr);
            2: phase_late = 1'b1;
            3: phase_late = tog;
            default: phase_late = 1'b0;
        endcase
    end

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic int late_votes(input int m, input int t, input int tp);
        case (m)
            0: return (tp >= t) ? VOTES : 0;
            2: return VOTES;
            3: return VOTES / 2;
            default: return 0;
        endcase
    endfunction

    // Window-by-window search from the decision rules.
    function automatic exp_t model(input int m, input int t);
        exp_t e;
        int tp = TAPINIT;
        int prev = 0;
        int windows = 0;
        int late, dir;
        e.lock = 0;
        e.err = 0;
        forever begin
            windows++;
            late = late_votes(m, t, tp);
            if (2 * late == VOTES) begin
                e.lock = 1;
                break;
            end
            dir = (2 * late > VOTES) ? -1 : 1;
            if (prev != 0 && dir != prev) begin
                e.lock = 1;
                break;
            end
            if ((dir == 1 && tp == MaxTap) || (dir == -1 && tp == 0)) begin
                e.err = 1;
                break;
            end
            tp += dir;
            prev = dir;
        end
        e.tap = tp;
        e.lat = windows * Window;
        e.start_cyc = 0;
        return e;
    endfunction

    // Monitor: a falling busy marks the end of a calibration.
    initial begin
        logic busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset && busy_prev && !busy) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("done_tap", int'(tap), e.tap);
                    check("done_locked", int'(locked), e.lock);
                    check("done_error", int'(error), e.err);
                    check("done_latency", cyc - e.start_cyc, e.lat);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_tap"}, int'(tap), TAPINIT);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_error"}, int'(error), 0);
    endtask

    task automatic issue(input int m, input int t, output exp_t e);
        mode = m;
        thr = t;
        e = model(m, t);
        @(negedge clk);
        start = 1'b1;
        e.start_cyc = cyc + 1;
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", int'(busy), 1);
        check("locked_after_start", int'(locked), 0);
    endtask

    task automatic run_cal(input int m, input int t, input bit noisy);
        exp_t e;
        issue(m, t, e);
        for (int i = 0; i < 600 && exp_q.size() != 0; i++) begin
            @(negedge clk);
            start = (noisy && (cyc + 3 < e.start_cyc + e.lat) && $urandom_range(0, 7) == 0);
        end
        start = 1'b0;
        if (exp_q.size() != 0) begin
            check("done_timeout", 0, 1);
            exp_q.delete();
        end
`ifndef LA_DELAYCTRL_TRACK_EN
        repeat (3 * Window) @(negedge clk);
        check("hold_tap", int'(tap), e.tap);
        check("hold_locked", int'(locked), e.lock);
        check("hold_error", int'(error), e.err);
`endif
    endtask

    initial begin
        exp_t e;
        bit seen;
        #2;
        check_reset_vals("por");
        @(negedge clk);
        reset = 1'b0;

        run_cal(0, 10, 1'b0);

        // Asynchronous reset with the clock stopped.
        @(negedge clk);
        clk_en = 1'b0;
        #3 reset = 1'b1;
        #1 check_reset_vals("async");
        #40 check_reset_vals("async_hold");
        reset = 1'b0;
        #2 clk_en = 1'b1;

        run_cal(1, 0, 1'b0);
        run_cal(3, 0, 1'b0);
        run_cal(2, 0, 1'b0);

        // Abort mid-calibration at tap 5.
        issue(0, 10, e);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(negedge clk);
            seen = (tap == 5);
        end
        check("reached_tap5", int'(seen), 1);
        #2 reset = 1'b1;
        #1 check_reset_vals("mid_abort");
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        run_cal(0, 10, 1'b1);

        for (int k = 0; k < 12; k++) begin
            run_cal(int'($urandom_range(0, 3)), int'($urandom_range(0, 40)),
                    1'($urandom_range(0, 1)));
        end

`ifdef LA_DELAYCTRL_TRACK_EN
        begin
            bit hit12;
            run_cal(0, 10, 1'b0);
            thr = 12;
            hit12 = 1'b0;
            for (int i = 0; i < 20 * Window; i++) begin
                @(negedge clk);
                check("track_locked", int'(locked), 1);
                check("track_error", int'(error), 0);
                if (hit12) check("track_dither", int'(tap == 11 || tap == 12), 1);
                else check("track_range", int'(tap >= 9 && tap <= 12), 1);
                if (tap == 12) hit12 = 1'b1;
            end
            check("track_reached_12", int'(hit12), 1);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
